game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
- Top-level game sequencer for the dino game.
- Owns the game state machine (idle / run / pause / over) and generates the single-cycle game tick that advances obstacles and the player.
- Shortens the tick period as play continues, down to a floor, to ramp difficulty.
- Keeps the score and difficulty level consumed by the display and renderer.

Parameters:
INIT_PERIOD, 160000, tick period in clk cycles at game start
MIN_PERIOD, 97000, floor for tick period
STEP, 9000, period decrement per speed-up
TICKS_PER_LEVEL, 10000, ticks between speed-up evaluations
SCORE_DIV, 16, ticks per score increment
CNT_W, 28, width of period counter and period register

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (asserted at 0)
start  in  1  one-cycle pulse; begin or restart a game
pause_tgl  in  1  one-cycle pulse; toggle pause
collide  in  1  level; player/obstacle collision this cycle
tick  out  1  one-cycle game tick pulse
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
level  out  4  number of speed-ups applied, saturates at 15
score  out  14  binary score, saturates at 9999
period  out  CNT_W  current tick period in cycles
game_over  out  1  high while state is OVER

Behaviour:
- Reset (rst=0, async): state=IDLE, tick=0, level=0, score=0, period=INIT_PERIOD, game_over=0, internal cycle counter=0, tick-per-level counter=0, score prescaler=0.
- All outputs are registered. game_over equals (state==OVER), registered.
- IDLE:
  - start -> RUN. On that edge, clear counter, level, score and prescalers, and load period=INIT_PERIOD.
  - collide and pause_tgl are ignored.
- RUN:
  - Priority: collide > pause_tgl > normal counting.
  - collide=1 -> OVER the next edge. tick is suppressed that cycle even if the counter is at terminal. Counter, score and level freeze.
  - pause_tgl=1 (no collide) -> PAUSE. Counter freezes at its current value and no tick is issued that cycle.
  - Otherwise: counter increments each cycle. When counter==period-1, tick=1 for exactly one cycle and the counter returns to 0. The tick period is therefore exactly `period` cycles.
  - start in RUN is ignored.
- Per tick (RUN only):
  - Score prescaler increments. When it reaches SCORE_DIV-1, it wraps to 0 and score increments. score saturates at 9999.
  - Level counter increments. When it reaches TICKS_PER_LEVEL-1, it wraps to 0 and a speed-up is evaluated:
    - new period = period-STEP if period-STEP >= MIN_PERIOD, else MIN_PERIOD.
    - level increments (saturating at 15) only if period actually decreased.
  - A new period takes effect from the next tick interval. The counter is already 0 at that point.
  - Subtraction uses CNT_W+1 bits so it cannot underflow.
- PAUSE:
  - pause_tgl -> RUN, resuming from the frozen counter value. The first tick after resume arrives after the remaining cycles, not after a full period.
  - collide is ignored. start is ignored. tick=0.
- OVER:
  - start -> RUN with a full clear, as from IDLE.
  - tick=0. score, level and period hold for display. pause_tgl and collide are ignored.
- Reset mid-game: immediate return to the reset values regardless of state. No tick glitch.
- Parameter constraints: INIT_PERIOD >= MIN_PERIOD >= 2; STEP >= 1; SCORE_DIV >= 1; TICKS_PER_LEVEL >= 1.

Test Plan:
- Defaults for the next four tests: INIT_PERIOD=10, MIN_PERIOD=4, STEP=3, TICKS_PER_LEVEL=2, SCORE_DIV=2.
- Reset/idle: hold rst=0, then release and wait 50 cycles with no start -> state=00, tick never asserted, period=10, score=0, level=0.
- Ramp: pulse start -> ticks at cycles 10 and 20 after start; period becomes 7, level=1; next ticks at +7, +7; period becomes 4, level=2; next evaluation leaves period=4 and level=2 (floor reached, no level increment); score=1 after the 2nd tick, 2 after the 4th.
- Pause: pulse pause_tgl 4 cycles after a tick -> state=10, no ticks for 30 cycles; pulse pause_tgl again -> next tick exactly 6 cycles later (period 10); collide during pause is ignored.
- Collision priority: assert collide in the same cycle the counter hits period-1 -> no tick, state=11, game_over=1, score and level frozen; then pulse start -> state=01, score=0, level=0, period=10.
- Saturation with INIT_PERIOD=2, MIN_PERIOD=2, SCORE_DIV=1: run more than 10000 ticks -> score stops at 9999 and level stays 0.
- Async reset: drive rst=0 mid-cycle while in RUN with level=2 -> outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between the dino-game sequencer and the rest of the game.
// The master drives the player/collision events; the slave publishes tick, state, score and speed.
interface game_tick_scheduler_if #(
    parameter int CNT_W = 28
);
    logic             start;
    logic             pause_tgl;
    logic             collide;
    logic             tick;
    logic [1:0]       state;
    logic [3:0]       level;
    logic [13:0]      score;
    logic [CNT_W-1:0] period;
    logic             game_over;

    modport master (
        output start, pause_tgl, collide,
        input  tick, state, level, score, period, game_over
    );

    modport slave (
        input  start, pause_tgl, collide,
        output tick, state, level, score, period, game_over
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Dino-game sequencer: idle/run/pause/over state machine, game tick generator with a
// shrinking period for difficulty ramp, and the score/level counters shown to the player.
module game_tick_scheduler #(
    parameter int INIT_PERIOD     = 160000,
    parameter int MIN_PERIOD      = 97000,
    parameter int STEP            = 9000,
    parameter int TICKS_PER_LEVEL = 10000,
    parameter int SCORE_DIV       = 16,
    parameter int CNT_W           = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    game_tick_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam int LVL_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
    localparam int PSC_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

    localparam logic [CNT_W-1:0] INIT_P    = CNT_W'(INIT_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W:0]   STEP_W    = (CNT_W+1)'(STEP);
    localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(TICKS_PER_LEVEL - 1);
    localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(SCORE_DIV - 1);
    localparam logic [13:0]      SCORE_MAX = 14'd9999;
    localparam logic [3:0]       LEVEL_MAX = 4'd15;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [3:0]       level_q, level_d;
    logic [13:0]      score_q, score_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [LVL_W-1:0] lvl_cnt_q, lvl_cnt_d;
    logic             tick_q, tick_d;
    logic             game_over_q, game_over_d;

    logic [CNT_W:0]   period_dec;
    logic [CNT_W-1:0] period_new;
    logic             terminal;

    // One extra bit on the subtraction so a large STEP shows up as a borrow, not a wrap.
    assign period_dec = {1'b0, period_q} - STEP_W;
    assign period_new = (period_dec[CNT_W] || (period_dec < {1'b0, MIN_P}))
                        ? MIN_P : period_dec[CNT_W-1:0];
    assign terminal   = (cnt_q == (period_q - CNT_W'(1)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        level_d   = level_q;
        score_d   = score_q;
        psc_d     = psc_q;
        lvl_cnt_d = lvl_cnt_q;
        tick_d    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    period_d  = INIT_P;
                    level_d   = '0;
                    score_d   = '0;
                    psc_d     = '0;
                    lvl_cnt_d = '0;
                end
            end
            ST_RUN: begin
                // Collision wins over pause and over a tick due this same cycle.
                if (bus.collide) begin
                    state_d = ST_OVER;
                end else if (bus.pause_tgl) begin
                    state_d = ST_PAUSE;
                end else if (terminal) begin
                    tick_d = 1'b1;
                    cnt_d  = '0;

                    if (psc_q == PSC_LAST) begin
                        psc_d = '0;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + 14'd1;
                        end
                    end else begin
                        psc_d = psc_q + PSC_W'(1);
                    end

                    // The new period applies from the next interval; cnt is already back at 0.
                    if (lvl_cnt_q == LVL_LAST) begin
                        lvl_cnt_d = '0;
                        period_d  = period_new;
                        if ((period_new < period_q) && (level_q != LEVEL_MAX)) begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        lvl_cnt_d = lvl_cnt_q + LVL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PAUSE: begin
                if (bus.pause_tgl) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= INIT_P;
            level_q     <= '0;
            score_q     <= '0;
            psc_q       <= '0;
            lvl_cnt_q   <= '0;
            tick_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            level_q     <= level_d;
            score_q     <= score_d;
            psc_q       <= psc_d;
            lvl_cnt_q   <= lvl_cnt_d;
            tick_q      <= tick_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.state     = state_q;
    assign bus.level     = level_q;
    assign bus.score     = score_q;
    assign bus.period    = period_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler: a small-parameter instance under random play
// against an interval/tick-count model, plus a fast instance exercising score saturation.
module tb_game_tick_scheduler;

    localparam int CW     = 28;
    localparam int A_INIT = 10;
    localparam int A_MIN  = 4;
    localparam int A_STEP = 3;
    localparam int A_TPL  = 2;
    localparam int A_SD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    game_tick_scheduler_if #(.CNT_W(CW)) ifa ();
    game_tick_scheduler_if #(.CNT_W(CW)) ifb ();

    game_tick_scheduler #(
        .INIT_PERIOD(A_INIT), .MIN_PERIOD(A_MIN), .STEP(A_STEP),
        .TICKS_PER_LEVEL(A_TPL), .SCORE_DIV(A_SD), .CNT_W(CW)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    game_tick_scheduler #(
        .INIT_PERIOD(2), .MIN_PERIOD(2), .STEP(1),
        .TICKS_PER_LEVEL(1), .SCORE_DIV(1), .CNT_W(CW)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit tick;
        int state;
        int score;
        int level;
        int period;
    } ev_t;
    ev_t sb[$];

    // Reference model: remaining cycles in the interval plus total tick count.
    int m_state, m_left, m_ticks, m_score, m_level, m_period;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic void m_recompute();
        int evals, dec_max, decs;
        evals   = m_ticks / A_TPL;
        dec_max = (A_INIT - A_MIN + A_STEP - 1) / A_STEP;
        decs    = (evals < dec_max) ? evals : dec_max;
        m_level = (decs > 15) ? 15 : decs;
        m_period = A_INIT - evals * A_STEP;
        if (m_period < A_MIN) m_period = A_MIN;
        m_score = m_ticks / A_SD;
        if (m_score > 9999) m_score = 9999;
    endfunction

    task automatic m_step(input bit s, input bit p, input bit c);
        int  prev;
        bit  t;
        ev_t e;
        prev = m_state;
        t    = 1'b0;
        case (m_state)
            0, 3: if (s) begin
                m_state = 1;
                m_ticks = 0;
                m_recompute();
                m_left = m_period;
            end
            1: begin
                if (c) m_state = 3;
                else if (p) m_state = 2;
                else if (m_left == 1) begin
                    t = 1'b1;
                    m_ticks++;
                    m_recompute();
                    m_left = m_period;
                end else m_left--;
            end
            default: if (p) m_state = 1;
        endcase
        if (t || m_state != prev) begin
            e.cyc = cyc + 1; e.tick = t; e.state = m_state;
            e.score = m_score; e.level = m_level; e.period = m_period;
            sb.push_back(e);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs and advance to the next falling edge.
    task automatic cycle(input bit s, input bit p, input bit c);
        ifa.start = s; ifa.pause_tgl = p; ifa.collide = c;
        m_step(s, p, c);
        @(negedge clk);
        ifa.start = 1'b0; ifa.pause_tgl = 1'b0; ifa.collide = 1'b0;
    endtask

    bit  mon_en = 1'b0;
    int  last_state = 0;
    ev_t me;
    always @(negedge clk) begin
        if (mon_en) begin
            if (ifa.tick || int'(ifa.state) != last_state) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL txn@%0d: unexpected tick=%0b state=%0d, none required",
                             cyc, ifa.tick, ifa.state);
                end else begin
                    me = sb.pop_front();
                    if (me.cyc != cyc || ifa.tick != me.tick || int'(ifa.state) != me.state ||
                        int'(ifa.score) != me.score || int'(ifa.level) != me.level ||
                        int'(ifa.period) != me.period || ifa.game_over != (me.state == 3)) begin
                        errors++;
                        $display("FAIL txn@%0d: got tick=%0b state=%0d score=%0d level=%0d period=%0d go=%0b required cyc=%0d tick=%0b state=%0d score=%0d level=%0d period=%0d",
                                 cyc, ifa.tick, ifa.state, ifa.score, ifa.level, ifa.period,
                                 ifa.game_over, me.cyc, me.tick, me.state, me.score, me.level, me.period);
                    end else begin
                        $display("txn cyc=%0d tick=%0b state=%0d score=%0d level=%0d period=%0d ok",
                                 cyc, me.tick, me.state, me.score, me.level, me.period);
                    end
                end
            end
            last_state = int'(ifa.state);
        end
    end

    bit mon_b = 1'b0;
    int b_ticks = 0;
    int b_exp;
    always @(negedge clk) begin
        if (mon_b && ifb.tick) begin
            b_ticks++;
            b_exp = (b_ticks > 9999) ? 9999 : b_ticks;
            checks++;
            if (int'(ifb.score) != b_exp || ifb.level != 4'd0 || int'(ifb.period) != 2) begin
                errors++;
                $display("FAIL sat_tick %0d: got score=%0d level=%0d period=%0d required score=%0d level=0 period=2",
                         b_ticks, ifb.score, ifb.level, ifb.period, b_exp);
            end
        end
    end

    initial begin
        bit s, p, c, restarted;
        ifa.start = 1'b0; ifa.pause_tgl = 1'b0; ifa.collide = 1'b0;
        ifb.start = 1'b0; ifb.pause_tgl = 1'b0; ifb.collide = 1'b0;
        m_state = 0; m_ticks = 0; m_recompute(); m_left = m_period;

        #12;
        chk("rst_state", ifa.state, 0);
        chk("rst_tick", ifa.tick, 0);
        chk("rst_period", ifa.period, A_INIT);
        chk("rst_score", ifa.score, 0);
        chk("rst_level", ifa.level, 0);
        chk("rst_game_over", ifa.game_over, 0);
        chk("rst_b_period", ifb.period, 2);

        @(negedge clk);
        rst = 1'b1;
        last_state = 0;
        mon_en = 1'b1;
        repeat (50) cycle(1'b0, 1'b1, 1'b1);
        chk("idle_state", ifa.state, 0);
        chk("idle_period", ifa.period, A_INIT);
        chk("idle_score", ifa.score, 0);
        chk("idle_level", ifa.level, 0);

        // Ramp through the floor: 10,10,7,7,4,4 then held.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (60) cycle(1'b0, 1'b0, 1'b0);

        // Collide on the terminal cycle, then restart.
        for (int i = 0; i < 20 && m_left != 1; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Pause mid-interval with a collide while paused, then resume.
        for (int i = 0; i < 20 && m_left != A_INIT; i++) cycle(1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (15) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        repeat (14) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            s = 1'b0; p = 1'b0; c = 1'b0;
            case (m_state)
                1: begin
                    s = ($urandom_range(0, 29) == 0);
                    p = ($urandom_range(0, 49) == 0);
                    c = ($urandom_range(0, 299) == 0) ||
                        (m_left == 1 && $urandom_range(0, 3) == 0);
                end
                2: begin
                    s = ($urandom_range(0, 9) == 0);
                    p = ($urandom_range(0, 14) == 0);
                    c = ($urandom_range(0, 4) == 0);
                end
                default: begin
                    s = ($urandom_range(0, 14) == 0);
                    p = ($urandom_range(0, 4) == 0);
                    c = ($urandom_range(0, 4) == 0);
                end
            endcase
            cycle(s, p, c);
        end

        ifb.start = 1'b1;
        mon_b = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        ifb.start = 1'b0;
        repeat (20300) cycle(1'b0, 1'b0, 1'b0);
        chk("sat_enough_ticks", (b_ticks > 10000), 1);
        chk("sat_score", ifb.score, 9999);
        chk("sat_level", ifb.level, 0);
        mon_b = 1'b0;

        // Fresh game on A, run to level 2, then pull reset between clock edges.
        restarted = 1'b0;
        for (int i = 0; i < 8 && !(restarted && m_state == 1); i++) begin
            if (m_state == 2) cycle(1'b0, 1'b1, 1'b0);
            else if (m_state == 1) cycle(1'b0, 1'b0, 1'b1);
            else begin
                cycle(1'b1, 1'b0, 1'b0);
                restarted = 1'b1;
            end
        end
        for (int i = 0; i < 200 && m_level < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("pre_async_level", ifa.level, 2);
        chk("pre_async_state", ifa.state, 1);

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("missing_txns", (sb.size() > 0 && sb[0].cyc < cyc), 0);
        rst = 1'b0;
        #1;
        chk("async_state", ifa.state, 0);
        chk("async_tick", ifa.tick, 0);
        chk("async_level", ifa.level, 0);
        chk("async_score", ifa.score, 0);
        chk("async_period", ifa.period, A_INIT);
        chk("async_game_over", ifa.game_over, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
